// File: rtl/ext_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_pkg
// Description : Shared constants and width helpers for the external memory
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_mem_pkg;

    localparam int STAT_W = 16;

    // Smallest width able to index n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Packed width of a {err, data} response for any data width.
    function automatic int rsp_width(input int data_w);
        return data_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_if
// Description : Request (valid/ready) and read-response channels of one
//               external memory instance.
// Revision    : 1.0 - initial release
// ============================================================================
interface ext_mem_if #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 12
) ();

    logic              REQ_VALID;
    logic              REQ_READY;
    logic              REQ_WR;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic [DATA_W-1:0] REQ_WDATA;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [DATA_W-1:0] RSP_RDATA;
    logic              RSP_ERR;

    modport master (
        output REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, RSP_READY,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
    );

    modport slave (
        input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, RSP_READY,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
    );

endinterface
`default_nettype wire

// File: rtl/ext_mem_ctrl_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_rsp_fifo
// Description : Synchronous response FIFO; head data reads as zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_mem_rsp_fifo
    import ext_mem_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  wire logic                              CLK,
    input  wire logic                              RST_N,
    input  wire logic                              push,
    input  wire logic [WIDTH-1:0]                  wdata,
    input  wire logic                              pop,
    output logic      [WIDTH-1:0]                  rdata,
    output logic                                   full,
    output logic                                   empty,
    output logic      [clog2_min1(DEPTH+1)-1:0]    count
);

    localparam int c_cnt_w = clog2_min1(DEPTH + 1);
    localparam int c_ptr_w = clog2_min1(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (r_count == c_cnt_w'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = empty ? '0 : r_mem[r_rptr];

    // A pop frees the slot being written, so push-on-full is legal alongside it.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= next_ptr(r_wptr);
            if (w_pop)  r_rptr <= next_ptr(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/ext_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_ctrl
// Description : External word memory with valid/ready requests, fixed read
//               latency and an in-order buffered response channel.
//               Optional macro EXT_MEM_STATS_EN adds STAT_RD/STAT_WR counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_mem_ctrl
    import ext_mem_pkg::*;
#(
    parameter int DATA_W    = 19,
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 4096,
    parameter int LATENCY   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  wire logic              CLK,
    input  wire logic              RST_N,
    ext_mem_if.slave               bus
`ifdef EXT_MEM_STATS_EN
    ,
    output logic      [STAT_W-1:0] STAT_RD,
    output logic      [STAT_W-1:0] STAT_WR
`endif
);

    localparam int              c_idx_w  = clog2_min1(DEPTH);
    localparam int              c_cnt_w  = clog2_min1(RSP_DEPTH + 1);
    localparam int              c_rsp_w  = rsp_width(DATA_W);
    localparam logic [ADDR_W:0] c_depth  = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_cnt_w:0] c_limit = (c_cnt_w + 1)'(RSP_DEPTH);

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0]   r_written;
    logic               r_rst_done;
    rsp_t               r_pipe [LATENCY];
    logic [LATENCY-1:0] r_pv;
    logic [c_cnt_w-1:0] r_inflight;

    logic               w_acc;
    logic               w_rd_acc;
    logic               w_wr_acc;
    logic               w_in_range;
    logic [c_idx_w-1:0] w_idx;
    rsp_t               w_rd_rsp;
    logic               w_push;
    rsp_t               w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic [c_cnt_w:0]   w_credit;

    assign w_acc      = bus.REQ_VALID && bus.REQ_READY;
    assign w_rd_acc   = w_acc && !bus.REQ_WR;
    assign w_wr_acc   = w_acc &&  bus.REQ_WR;
    assign w_in_range = ({1'b0, bus.REQ_ADDR} < c_depth);
    assign w_idx      = bus.REQ_ADDR[c_idx_w-1:0];

    // Never-written words read as zero; out-of-range reads flag err with zero data.
    assign w_rd_rsp.err  = !w_in_range;
    assign w_rd_rsp.data = (w_in_range && r_written[w_idx]) ? r_mem[w_idx] : '0;

    // Each in-flight read already owns a FIFO slot, so pushes can never overflow.
    assign w_credit      = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign bus.REQ_READY = r_rst_done && (w_credit < c_limit);

    assign w_push = r_pv[LATENCY-1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rst_done <= 1'b0;
            r_written  <= '0;
            r_pv       <= '0;
            r_inflight <= '0;
            for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_wr_acc && w_in_range) r_written[w_idx] <= 1'b1;
            r_pv[0]   <= w_rd_acc;
            r_pipe[0] <= w_rd_rsp;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_pipe[i] <= r_pipe[i-1];
            end
            case ({w_rd_acc, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_acc && w_in_range) r_mem[w_idx] <= bus.REQ_WDATA;
    end

    ext_mem_rsp_fifo #(
        .WIDTH (c_rsp_w),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (w_push),
        .wdata (r_pipe[LATENCY-1]),
        .pop   (bus.RSP_READY),
        .rdata (w_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign bus.RSP_VALID = !w_fifo_empty;
    assign bus.RSP_RDATA = w_head.data;
    assign bus.RSP_ERR   = w_head.err;

    a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
        !(w_push && w_fifo_full && !bus.RSP_READY));

`ifdef EXT_MEM_STATS_EN
    logic [STAT_W-1:0] r_stat_rd;
    logic [STAT_W-1:0] r_stat_wr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stat_rd <= '0;
            r_stat_wr <= '0;
        end else begin
            if (w_rd_acc && (r_stat_rd != '1)) r_stat_rd <= r_stat_rd + 1'b1;
            if (w_wr_acc && (r_stat_wr != '1)) r_stat_wr <= r_stat_wr + 1'b1;
        end
    end

    assign STAT_RD = r_stat_rd;
    assign STAT_WR = r_stat_wr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ext_mem_ctrl
// Description : Scoreboard bench for ext_mem_ctrl (DEPTH=1024, LATENCY=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_mem_ctrl;
    import ext_mem_pkg::*;

    typedef struct packed {
        logic        err;
        logic [18:0] data;
    } exp_t;

    logic CLK;
    logic RST_N;
    int   checks = 0;
    int   errors = 0;
    int   n_rd   = 0;
    exp_t exp_q [$];
    exp_t mon_e;

    ext_mem_if #(.DATA_W(19), .ADDR_W(12)) bus ();

`ifdef EXT_MEM_STATS_EN
    logic [STAT_W-1:0] stat_rd;
    logic [STAT_W-1:0] stat_wr;
`endif

    ext_mem_ctrl #(
        .DATA_W    (19),
        .ADDR_W    (12),
        .DEPTH     (1024),
        .LATENCY   (2),
        .RSP_DEPTH (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
`ifdef EXT_MEM_STATS_EN
        ,
        .STAT_RD (stat_rd),
        .STAT_WR (stat_wr)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Holds the request until accepted; returns just after the accepting edge.
    task automatic req(input logic wr, input logic [11:0] a, input logic [18:0] d);
        int n = 0;
        @(negedge CLK);
        bus.REQ_VALID = 1'b1;
        bus.REQ_WR    = wr;
        bus.REQ_ADDR  = a;
        bus.REQ_WDATA = d;
        while (!bus.REQ_READY && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!bus.REQ_READY) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got REQ_READY=0 for 50 cycles, expected 1");
        end
        @(posedge CLK);
        if (!wr) n_rd++;
        #1 bus.REQ_VALID = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic err, input logic [18:0] d);
        exp_q.push_back('{err: err, data: d});
        req(1'b0, a, 19'h0);
    endtask

    // Counts negedges after the accepting edge until RSP_VALID rises.
    task automatic wait_lat(input string name);
        int k = 0;
        @(negedge CLK);
        while (!bus.RSP_VALID && k < 10) begin
            k++;
            @(negedge CLK);
        end
        check(name, k, 2);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d responses pending, expected 0", exp_q.size());
        end
        repeat (2) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (RST_N && bus.RSP_VALID && bus.RSP_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got data 0x%0h err %0b, expected no response",
                         bus.RSP_RDATA, bus.RSP_ERR);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_data", 32'(bus.RSP_RDATA), 32'(mon_e.data));
                check("rsp_err",  32'(bus.RSP_ERR),   32'(mon_e.err));
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [18:0] bp_vals [4];
    int          acc;

    initial begin
        bp_vals = '{19'h11111, 19'h22222, 19'h33333, 19'h44444};
        RST_N         = 1'b0;
        bus.REQ_VALID = 1'b0;
        bus.REQ_WR    = 1'b0;
        bus.REQ_ADDR  = '0;
        bus.REQ_WDATA = '0;
        bus.RSP_READY = 1'b1;

        repeat (3) @(negedge CLK);
        check("rst_req_ready", 32'(bus.REQ_READY), 0);
        check("rst_rsp_valid", 32'(bus.RSP_VALID), 0);
        check("rst_rsp_rdata", 32'(bus.RSP_RDATA), 0);
        check("rst_rsp_err",   32'(bus.RSP_ERR),   0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        check("post_rst_ready", 32'(bus.REQ_READY), 1);

        // Unwritten word and read-after-write latency.
        rd(12'h005, 1'b0, 19'h0);
        wait_lat("lat_unwritten");
        drain();
        req(1'b1, 12'h010, 19'h7FFFF);
        rd(12'h010, 1'b0, 19'h7FFFF);
        wait_lat("lat_raw");
        drain();

        // Out-of-range write dropped; must not alias onto word 0.
        req(1'b1, 12'h400, 19'h01234);
        rd(12'h400, 1'b1, 19'h0);
        rd(12'h000, 1'b0, 19'h0);
        rd(12'h3FF, 1'b0, 19'h0);
        drain();

        // Back-pressure: only RSP_DEPTH reads accepted while RSP_READY is low.
        for (int i = 0; i < 4; i++) req(1'b1, 12'h100 + 12'(i), bp_vals[i]);
        @(posedge CLK);
        #1 bus.RSP_READY = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            bus.REQ_VALID = 1'b1;
            bus.REQ_WR    = 1'b0;
            bus.REQ_ADDR  = 12'h100 + 12'(acc);
            if (bus.REQ_READY) begin
                exp_q.push_back('{err: 1'b0, data: bp_vals[acc]});
                acc++;
                n_rd++;
            end
            @(posedge CLK);
            #1;
        end
        bus.REQ_VALID = 1'b0;
        check("bp_accepted", acc, 4);
        @(negedge CLK);
        check("bp_ready_low", 32'(bus.REQ_READY), 0);
        check("bp_stall_valid", 32'(bus.RSP_VALID), 1);
        check("bp_stall_rdata", 32'(bus.RSP_RDATA), 32'(bp_vals[0]));
        @(negedge CLK);
        check("bp_hold_rdata", 32'(bus.RSP_RDATA), 32'(bp_vals[0]));
        check("bp_hold_err", 32'(bus.RSP_ERR), 0);
        @(posedge CLK);
        #1 bus.RSP_READY = 1'b1;
        @(negedge CLK);
        check("bp_ready_before_pop", 32'(bus.REQ_READY), 0);
        @(negedge CLK);
        check("bp_ready_after_pop", 32'(bus.REQ_READY), 1);
        drain();

        // Mid-stream reset with two reads in flight.
        req(1'b1, 12'h020, 19'h003AB);
        req(1'b0, 12'h020, 19'h0);
        req(1'b0, 12'h020, 19'h0);
        RST_N = 1'b0;
        @(negedge CLK);
        check("mid_rst_ready", 32'(bus.REQ_READY), 0);
        check("mid_rst_valid", 32'(bus.RSP_VALID), 0);
        check("mid_rst_rdata", 32'(bus.RSP_RDATA), 0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
        n_rd = 0;
        repeat (6) @(negedge CLK);
        check("mid_rst_flush", 32'(bus.RSP_VALID), 0);
        rd(12'h020, 1'b0, 19'h0);
        drain();

`ifdef EXT_MEM_STATS_EN
        for (int i = 0; i < 70000; i++) req(1'b1, 12'h050, 19'(i));
        @(negedge CLK);
        check("stat_wr_sat", 32'(stat_wr), 32'hFFFF);
        check("stat_rd", 32'(stat_rd), 32'(n_rd));
`endif

        drain();
        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
